// File: rtl/dcache_dm_if.sv
// dcache_dm bus types and the processor/memory port bundle.
// Ports: proc2cache request, cache2proc response, cache2mem request, mem2cache response/fill.
package dcache_pkg;
   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;
endpackage

interface dcache_dm_if #(parameter int XLEN = 32);
   import dcache_pkg::*;
   logic             proc2cache_req_valid;
   BUS_COMMAND       proc2cache_command;
   logic [XLEN-1:0]  proc2cache_addr;
   logic [XLEN-1:0]  proc2cache_data;
   logic [1:0]       proc2cache_size;
   logic             proc2cache_unsigned;
   logic             cache2proc_done;
   logic [XLEN-1:0]  cache2proc_data;
   BUS_COMMAND       cache2mem_command;
   logic [XLEN-1:0]  cache2mem_addr;
   logic [63:0]      cache2mem_data;
   logic [3:0]       mem2cache_response;
   logic [63:0]      mem2cache_data;
   logic [3:0]       mem2cache_tag;

   modport slave (
      input  proc2cache_req_valid, proc2cache_command, proc2cache_addr,
      input  proc2cache_data, proc2cache_size, proc2cache_unsigned,
      output cache2proc_done, cache2proc_data,
      output cache2mem_command, cache2mem_addr, cache2mem_data,
      input  mem2cache_response, mem2cache_data, mem2cache_tag
   );

   modport master (
      output proc2cache_req_valid, proc2cache_command, proc2cache_addr,
      output proc2cache_data, proc2cache_size, proc2cache_unsigned,
      input  cache2proc_done, cache2proc_data,
      input  cache2mem_command, cache2mem_addr, cache2mem_data,
      output mem2cache_response, mem2cache_data, mem2cache_tag
   );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-through write-allocate data cache, 8-byte lines.
// Ports: clk, rst (async, active-high), bus (dcache_dm_if.slave: proc and mem sides).
module dcache_dm
   import dcache_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_LINES = 32
) (
   input logic        clk,
   input logic        rst,
   dcache_dm_if.slave bus
);
   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = XLEN - 3 - IDX_BITS;

   typedef enum logic [2:0] {
      IDLE, MISS_REQ, MISS_WAIT, STORE_REQ, RESP
   } state_t;

   state_t state, state_n;

   logic [NUM_LINES-1:0] line_valid;
   logic [TAG_BITS-1:0]  line_tag  [NUM_LINES];
   logic [63:0]          line_data [NUM_LINES];

   BUS_COMMAND      r_cmd;
   logic [XLEN-1:0] r_addr, r_data;
   logic [1:0]      r_size;
   logic            r_uns;
   logic [3:0]      r_mtag;

   BUS_COMMAND      mem_cmd, mem_cmd_n;
   logic [XLEN-1:0] mem_addr, mem_addr_n;
   logic [63:0]     mem_data, mem_data_n;

   logic                latch_req, latch_mtag, wr_en;
   logic [IDX_BITS-1:0] wr_idx;
   logic [TAG_BITS-1:0] wr_tag;
   logic [63:0]         wr_line;

   function automatic logic [63:0] merge(input logic [63:0] line,
                                         input logic [2:0] off,
                                         input logic [1:0] size,
                                         input logic [XLEN-1:0] d);
      logic [63:0] m;
      m = line;
      case (size)
         2'd0:    m[{off, 3'b000} +: 8] = d[7:0];
         2'd1:    m[{off[2:1], 4'b0000} +: 16] = d[15:0];
         default: m[{off[2], 5'b00000} +: 32] = d[31:0];
      endcase
      return m;
   endfunction

   function automatic logic [XLEN-1:0] extract(input logic [63:0] line,
                                               input logic [2:0] off,
                                               input logic [1:0] size,
                                               input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      logic [XLEN-1:0] r;
      b = line[{off, 3'b000} +: 8];
      h = line[{off[2:1], 4'b0000} +: 16];
      w = line[{off[2], 5'b00000} +: 32];
      case (size)
         2'd0:    r = uns ? XLEN'(b) : XLEN'($signed(b));
         2'd1:    r = uns ? XLEN'(h) : XLEN'($signed(h));
         default: r = uns ? XLEN'(w) : XLEN'($signed(w));
      endcase
      return r;
   endfunction

   logic [IDX_BITS-1:0] in_idx, r_idx;
   logic [TAG_BITS-1:0] in_tag, r_tag;
   logic                in_hit;

   assign in_idx = bus.proc2cache_addr[3+IDX_BITS-1:3];
   assign in_tag = bus.proc2cache_addr[XLEN-1:3+IDX_BITS];
   assign in_hit = line_valid[in_idx] && (line_tag[in_idx] == in_tag);
   assign r_idx  = r_addr[3+IDX_BITS-1:3];
   assign r_tag  = r_addr[XLEN-1:3+IDX_BITS];

   always_comb begin
      state_n    = state;
      latch_req  = 1'b0;
      latch_mtag = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = r_idx;
      wr_tag     = r_tag;
      wr_line    = bus.mem2cache_data;
      mem_cmd_n  = mem_cmd;
      mem_addr_n = mem_addr;
      mem_data_n = mem_data;
      unique case (state)
         IDLE: begin
            if (bus.proc2cache_req_valid &&
                bus.proc2cache_command != BUS_NONE) begin
               latch_req  = 1'b1;
               mem_addr_n = {bus.proc2cache_addr[XLEN-1:3], 3'b000};
               if (in_hit && bus.proc2cache_command == BUS_LOAD) begin
                  state_n    = RESP;
                  mem_addr_n = mem_addr;
               end else if (in_hit) begin
                  // store hit: line updated as the BUS_STORE goes out
                  state_n    = STORE_REQ;
                  wr_en      = 1'b1;
                  wr_idx     = in_idx;
                  wr_tag     = in_tag;
                  wr_line    = merge(line_data[in_idx],
                                     bus.proc2cache_addr[2:0],
                                     bus.proc2cache_size,
                                     bus.proc2cache_data);
                  mem_cmd_n  = BUS_STORE;
                  mem_data_n = wr_line;
               end else begin
                  state_n   = MISS_REQ;
                  mem_cmd_n = BUS_LOAD;
               end
            end
         end
         MISS_REQ: begin
            if (bus.mem2cache_response != 4'd0) begin
               latch_mtag = 1'b1;
               mem_cmd_n  = BUS_NONE;
               state_n    = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (r_mtag != 4'd0 && bus.mem2cache_tag == r_mtag) begin
               wr_en = 1'b1;
               if (r_cmd == BUS_STORE) begin
                  wr_line    = merge(bus.mem2cache_data, r_addr[2:0],
                                     r_size, r_data);
                  mem_cmd_n  = BUS_STORE;
                  mem_data_n = wr_line;
                  state_n    = STORE_REQ;
               end else begin
                  state_n = RESP;
               end
            end
         end
         STORE_REQ: begin
            if (bus.mem2cache_response != 4'd0) begin
               mem_cmd_n = BUS_NONE;
               state_n   = RESP;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         line_valid <= '0;
         r_cmd      <= BUS_NONE;
         r_addr     <= '0;
         r_data     <= '0;
         r_size     <= '0;
         r_uns      <= 1'b0;
         r_mtag     <= '0;
         mem_cmd    <= BUS_NONE;
         mem_addr   <= '0;
         mem_data   <= '0;
      end else begin
         state    <= state_n;
         mem_cmd  <= mem_cmd_n;
         mem_addr <= mem_addr_n;
         mem_data <= mem_data_n;
         if (latch_req) begin
            r_cmd  <= bus.proc2cache_command;
            r_addr <= bus.proc2cache_addr;
            r_data <= bus.proc2cache_data;
            r_size <= bus.proc2cache_size;
            r_uns  <= bus.proc2cache_unsigned;
         end
         if (latch_mtag) r_mtag <= bus.mem2cache_response;
         if (wr_en) line_valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_tag[wr_idx]  <= wr_tag;
         line_data[wr_idx] <= wr_line;
      end
   end

   assign bus.cache2proc_done   = (state == RESP);
   assign bus.cache2proc_data   = (state == RESP && r_cmd == BUS_LOAD) ?
                                  extract(line_data[r_idx], r_addr[2:0],
                                          r_size, r_uns) : '0;
   assign bus.cache2mem_command = mem_cmd;
   assign bus.cache2mem_addr    = mem_addr;
   assign bus.cache2mem_data    = mem_data;
endmodule
